// File: rtl/acc_bcd_converter.sv
// Iterative double-dabble binary-to-BCD converter for the accumulator display.
// One bit per clock; result held stable between completions.
module acc_bcd_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);
  always_comb q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module acc_bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clocks,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      value,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int BW = 4*DIGITS;
  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [BW-1:0]     scratch_q, scratch_d;
  logic [CW-1:0]     count_q, count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [BW-1:0]     bcd_q, bcd_d;

  logic [BW-1:0]     adj;
  logic [BW-1:0]     scratch_nxt;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      acc_bcd_digit u_dig (.d(scratch_q[4*g +: 4]), .q(adj[4*g +: 4]));
    end
  endgenerate

  // Top bit of the corrected scratch falls off; shift MSB enters at bit 0.
  assign scratch_nxt = {adj[BW-2:0], shift_q[WIDTH-1]};

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    count_d   = count_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = value;
          scratch_d = '0;
          count_d   = '0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        scratch_d = scratch_nxt;
        count_d   = count_q + CW'(1);
        if (count_q == CW'(WIDTH-1)) begin
          bcd_d   = scratch_nxt;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clocks or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
endmodule
